rr_stream_arb: RTL and testbench

//  N:1 round-robin arbiter that shares one valid/ready forward pipe stage between N streaming requesters.

---
 rtl/rr_stream_arb.sv | 114 +++++++++++
 tb/tb_rr_stream_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arb.sv
// N:1 packet-granular round-robin arbiter feeding one registered valid/ready output stage.
// The winner of a packet keeps the output until its last beat transfers; the pointer moves only on last beats.
module rr_stream_arb #(
  parameter int N  = 4,
  parameter int WD = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N-1:0]                            s_valid_i,
  input  logic [N*WD-1:0]                         s_data_i,
  input  logic [N-1:0]                            s_last_i,
  output logic [N-1:0]                            s_ready_o,
  output logic                                    m_valid_o,
  output logic [WD-1:0]                           m_data_o,
  output logic                                    m_last_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]    m_id_o,
  input  logic                                    m_ready_i
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic             m_valid_q, m_valid_d;
  logic [WD-1:0]    m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic [IDW-1:0]   m_id_q, m_id_d;

  logic [IDW-1:0]   rr_sel;
  logic [IDW:0]     idx;
  logic             found;
  logic [IDW-1:0]   sel;
  logic             accept;
  logic             xfer;

  // Circular priority search starting at ptr_q
  always_comb begin
    rr_sel = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!found && s_valid_i[idx[IDW-1:0]]) begin
        found  = 1'b1;
        rr_sel = idx[IDW-1:0];
      end
    end
  end

  assign sel    = (state_q == LOCK) ? gnt_q : rr_sel;
  assign accept = m_ready_i | ~m_valid_q;

  always_comb begin
    s_ready_o = '0;
    if (rst_n && accept && ((state_q == LOCK) || (|s_valid_i))) s_ready_o[sel] = 1'b1;
  end

  assign xfer = s_valid_i[sel] & s_ready_o[sel];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_i[int'(sel)*WD +: WD];
      m_last_d  = s_last_i[sel];
      m_id_d    = sel;
      if (s_last_i[sel]) begin
        state_d = IDLE;
        ptr_d   = (sel == IDW'(N-1)) ? '0 : sel + IDW'(1);
      end else begin
        state_d = LOCK;
        gnt_d   = sel;
      end
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_id_o    = m_id_q;

endmodule

// File: tb/tb_rr_stream_arb.sv
// Directed bench for rr_stream_arb (N=4, WD=8); output beats compared as {valid,last,id,data}.
module tb_rr_stream_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_last;
  logic [3:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  m_id;
  logic        m_ready;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rr_stream_arb #(.N(4), .WD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .s_ready_o (s_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_id_o    (m_id),
    .m_ready_i (m_ready)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0; s_valid = 4'hF; s_last = 4'hF; s_data = 32'h13121110; m_ready = 1'b1;
    repeat (3) cyc();
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'h000) begin nerr++; $display("FAIL reset_out got %h want %h", got, 12'h000); end
    nvec++; if (s_ready !== 4'b0000) begin nerr++; $display("FAIL reset_rdy got %b want %b", s_ready, 4'b0000); end
    rst_n = 1'b1;
    #1;
    nvec++; if (s_ready !== 4'b0001) begin nerr++; $display("FAIL reset_first_gnt got %b want %b", s_ready, 4'b0001); end
    s_last = 4'h1;
    cyc();
    s_valid = '0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hC10) begin nerr++; $display("FAIL reset_first_beat got %h want %h", got, 12'hC10); end
    cyc();
  endtask

  task automatic test_fairness();
    logic [11:0] got, exp;
    do_reset();
    s_valid = 4'hF; s_last = 4'hF; s_data = 32'h23222120;
    #1;
    nvec++; if (s_ready !== 4'b0001) begin nerr++; $display("FAIL fair_rdy0 got %b want %b", s_ready, 4'b0001); end
    for (int k = 0; k < 8; k++) begin
      cyc();
      exp = {1'b1, 1'b1, 2'(k % 4), 8'(8'h20 + k % 4)};
      got = {m_valid, m_last, m_id, m_data};
      nvec++; if (got !== exp) begin nerr++; $display("FAIL fair_beat%0d got %h want %h", k, got, exp); end
    end
    s_valid = '0;
    cyc();
  endtask

  task automatic test_packet_lock();
    logic [11:0] got;
    logic [7:0]  pkt [3];
    pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3;
    do_reset();
    s_valid = 4'b0110; s_data = 32'h00B2A100; s_last = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      s_data[15:8] = pkt[b];
      s_last[1]    = (b == 2);
      #1;
      nvec++; if (s_ready !== 4'b0010) begin nerr++; $display("FAIL lock_rdy%0d got %b want %b", b, s_ready, 4'b0010); end
      cyc();
      got = {m_valid, m_last, m_id, m_data};
      nvec++; if (got !== {1'b1, (b == 2), 2'd1, pkt[b]}) begin
        nerr++; $display("FAIL lock_beat%0d got %h want %h", b, got, {1'b1, (b == 2), 2'd1, pkt[b]});
      end
    end
    s_valid[1] = 1'b0;
    #1;
    nvec++; if (s_ready !== 4'b0100) begin nerr++; $display("FAIL lock_next_rdy got %b want %b", s_ready, 4'b0100); end
    cyc();
    s_valid = '0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hEB2) begin nerr++; $display("FAIL lock_next_beat got %h want %h", got, 12'hEB2); end
    cyc();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL lock_drain got %b want %b", m_valid, 1'b0); end
  endtask

  task automatic test_backpressure();
    logic [11:0] got;
    do_reset();
    s_valid = 4'b0001; s_data = 32'h3F000031; s_last = 4'b1000;
    cyc();
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'h831) begin nerr++; $display("FAIL bp_first got %h want %h", got, 12'h831); end
    s_valid = 4'b1001; s_data[7:0] = 8'h32; s_last = 4'b1001; m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      nvec++; if (s_ready !== 4'b0000) begin nerr++; $display("FAIL bp_rdy%0d got %b want %b", k, s_ready, 4'b0000); end
      cyc();
      got = {m_valid, m_last, m_id, m_data};
      nvec++; if (got !== 12'h831) begin nerr++; $display("FAIL bp_hold%0d got %h want %h", k, got, 12'h831); end
    end
    m_ready = 1'b1;
    #1;
    nvec++; if (s_ready !== 4'b0001) begin nerr++; $display("FAIL bp_release_rdy got %b want %b", s_ready, 4'b0001); end
    cyc();
    s_valid[0] = 1'b0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hC32) begin nerr++; $display("FAIL bp_second got %h want %h", got, 12'hC32); end
    #1;
    nvec++; if (s_ready !== 4'b1000) begin nerr++; $display("FAIL bp_req3_rdy got %b want %b", s_ready, 4'b1000); end
    cyc();
    s_valid = '0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hF3F) begin nerr++; $display("FAIL bp_req3_beat got %h want %h", got, 12'hF3F); end
    cyc();
  endtask

  task automatic test_wrap_skip();
    logic [11:0] got;
    do_reset();
    s_valid = 4'b0100; s_data = 32'h43004100; s_data[23:16] = 8'h42; s_last = 4'hF;
    cyc();
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hE42) begin nerr++; $display("FAIL wrap_setup got %h want %h", got, 12'hE42); end
    s_valid = 4'b1010;
    #1;
    nvec++; if (s_ready !== 4'b1000) begin nerr++; $display("FAIL wrap_rdy3 got %b want %b", s_ready, 4'b1000); end
    cyc();
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hF43) begin nerr++; $display("FAIL wrap_beat3 got %h want %h", got, 12'hF43); end
    s_data[31:24] = 8'h44;
    #1;
    nvec++; if (s_ready !== 4'b0010) begin nerr++; $display("FAIL wrap_rdy1 got %b want %b", s_ready, 4'b0010); end
    cyc();
    s_valid[1] = 1'b0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hD41) begin nerr++; $display("FAIL wrap_beat1 got %h want %h", got, 12'hD41); end
    cyc();
    s_valid = '0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hF44) begin nerr++; $display("FAIL wrap_beat3b got %h want %h", got, 12'hF44); end
    cyc();
  endtask

  task automatic test_bubble_reset();
    logic [11:0] got;
    do_reset();
    s_valid = 4'b0100; s_data = 32'h53515050; s_last = 4'b1001;
    cyc();
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hA51) begin nerr++; $display("FAIL bub_first got %h want %h", got, 12'hA51); end
    s_valid = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      #1;
      nvec++; if (s_ready !== 4'b0100) begin nerr++; $display("FAIL bub_rdy%0d got %b want %b", k, s_ready, 4'b0100); end
      cyc();
      nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL bub_gap%0d got %b want %b", k, m_valid, 1'b0); end
    end
    s_valid = 4'b1101; s_data[23:16] = 8'h52;
    cyc();
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hA52) begin nerr++; $display("FAIL bub_resume got %h want %h", got, 12'hA52); end
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    nvec++; if ({m_valid, s_ready} !== 5'b0) begin nerr++; $display("FAIL bub_rst got %b want %b", {m_valid, s_ready}, 5'b0); end
    cyc();
    m_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    nvec++; if (s_ready !== 4'b0001) begin nerr++; $display("FAIL bub_post_rdy got %b want %b", s_ready, 4'b0001); end
    cyc();
    s_valid = '0;
    got = {m_valid, m_last, m_id, m_data};
    nvec++; if (got !== 12'hC50) begin nerr++; $display("FAIL bub_post_beat got %h want %h", got, 12'hC50); end
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b1;
    test_reset();
    test_fairness();
    test_packet_lock();
    test_backpressure();
    test_wrap_skip();
    test_bubble_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
